// File: rtl/lfsr_req_sched.sv
// Round-robin scheduler sharing one external 7-bit Fibonacci LFSR among NREQ requesters.
// Owns the LFSR enable/load/seed; steps it STEPS times per grant and returns the value.
module lfsr_req_sched #(
  parameter int         NREQ  = 4,
  parameter int         STEPS = 1,
  parameter logic [6:0] SEED  = 7'h01
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            seed_load,
  input  logic [6:0]      seed_in,
  input  logic [NREQ-1:0] req,
  input  logic [6:0]      lfsr_q,
  output logic            lfsr_en,
  output logic            lfsr_load,
  output logic [6:0]      lfsr_seed,
  output logic [NREQ-1:0] gnt,
  output logic            rnd_valid,
  output logic [6:0]      rnd_data,
  output logic            period_done,
  output logic            busy
);

  localparam int         IW       = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [IW:0] NREQ_W  = (IW+1)'(NREQ);
  localparam logic [6:0] SEED_RST = (SEED == 7'h00) ? 7'h01 : SEED;
  localparam logic [6:0] STEPS_L  = 7'(STEPS);

  typedef enum logic [1:0] {S_INIT, S_IDLE, S_STEP, S_DELIVER} state_t;

  state_t          state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [IW-1:0]   gidx_q, gidx_d;
  logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [6:0]      rem_q, rem_d;
  logic [6:0]      step_cnt_q, step_cnt_d;
  logic [6:0]      seed_q, seed_d;
  logic [6:0]      rnd_data_q, rnd_data_d;
  logic            rnd_valid_q, rnd_valid_d;
  logic            period_done_q, period_done_d;
  logic            seed_pend_q, seed_pend_d;

  logic [2*NREQ-1:0] req_dbl;
  logic [NREQ-1:0]   req_rot;
  logic [IW-1:0]     pick_off, pick_idx;
  logic              req_any;

  function automatic logic [6:0] sanitize_seed(input logic [6:0] s);
    return (s == 7'h00) ? 7'h01 : s;
  endfunction

  function automatic logic [IW-1:0] add_wrap(input logic [IW-1:0] a, input logic [IW-1:0] b);
    logic [IW:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= NREQ_W) s = s - NREQ_W;
    return s[IW-1:0];
  endfunction

  // Rotate requests so bit 0 is rr_ptr; the lowest set bit is then the next in turn.
  assign req_dbl = {req, req} >> rr_ptr_q;
  assign req_rot = req_dbl[NREQ-1:0];
  assign req_any = |req;

  always_comb begin
    pick_off = '0;
    for (int k = NREQ-1; k >= 0; k--) begin
      if (req_rot[k]) pick_off = IW'(k);
    end
    pick_idx = add_wrap(rr_ptr_q, pick_off);
  end

  always_comb begin
    state_d       = state_q;
    gnt_d         = gnt_q;
    gidx_d        = gidx_q;
    rr_ptr_d      = rr_ptr_q;
    rem_d         = rem_q;
    rnd_valid_d   = 1'b0;
    rnd_data_d    = rnd_data_q;
    seed_d        = seed_q;
    seed_pend_d   = seed_pend_q;
    step_cnt_d    = step_cnt_q;
    period_done_d = 1'b0;
    lfsr_en       = 1'b0;
    lfsr_load     = 1'b0;

    case (state_q)
      S_INIT: begin
        lfsr_en     = 1'b1;
        lfsr_load   = 1'b1;
        seed_pend_d = 1'b0;
        step_cnt_d  = '0;
        state_d     = S_IDLE;
      end
      S_IDLE: begin
        gnt_d = '0;
        if (seed_pend_q) begin
          state_d = S_INIT;
        end else if (req_any) begin
          gnt_d   = {{(NREQ-1){1'b0}}, 1'b1} << pick_idx;
          gidx_d  = pick_idx;
          rem_d   = STEPS_L;
          state_d = S_STEP;
        end
      end
      S_STEP: begin
        lfsr_en = 1'b1;
        rem_d   = rem_q - 7'd1;
        if (step_cnt_q == 7'd126) begin
          step_cnt_d    = '0;
          period_done_d = 1'b1;
        end else begin
          step_cnt_d = step_cnt_q + 7'd1;
        end
        if (rem_q == 7'd1) state_d = S_DELIVER;
      end
      S_DELIVER: begin
        rnd_valid_d = 1'b1;
        rnd_data_d  = lfsr_q;
        rr_ptr_d    = add_wrap(gidx_q, IW'(1));
        state_d     = S_IDLE;
      end
      default: state_d = S_INIT;
    endcase

    // A new seed may arrive in any state, including INIT, and forces another INIT.
    if (seed_load) begin
      seed_d      = sanitize_seed(seed_in);
      seed_pend_d = 1'b1;
    end

    if (rst) begin
      lfsr_en   = 1'b0;
      lfsr_load = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_INIT;
      gnt_q         <= '0;
      gidx_q        <= '0;
      rr_ptr_q      <= '0;
      rem_q         <= '0;
      step_cnt_q    <= '0;
      seed_q        <= SEED_RST;
      rnd_data_q    <= '0;
      rnd_valid_q   <= 1'b0;
      period_done_q <= 1'b0;
      seed_pend_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      gnt_q         <= gnt_d;
      gidx_q        <= gidx_d;
      rr_ptr_q      <= rr_ptr_d;
      rem_q         <= rem_d;
      step_cnt_q    <= step_cnt_d;
      seed_q        <= seed_d;
      rnd_data_q    <= rnd_data_d;
      rnd_valid_q   <= rnd_valid_d;
      period_done_q <= period_done_d;
      seed_pend_q   <= seed_pend_d;
    end
  end

  assign lfsr_seed   = seed_q;
  assign gnt         = gnt_q;
  assign rnd_valid   = rnd_valid_q;
  assign rnd_data    = rnd_data_q;
  assign period_done = period_done_q;
  assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_lfsr_req_sched.sv
// Bench for lfsr_req_sched: drives an external LFSR, checks every cycle against a
// transaction-level model, plus directed sequences with known delivery values.
module tb_lfsr_req_sched;

  localparam int         NREQ  = 4;
  localparam int         STEPS = 1;
  localparam logic [6:0] SEED  = 7'h01;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            seed_load = 1'b0;
  logic [6:0]      seed_in = '0;
  logic [NREQ-1:0] req = '0;
  logic [6:0]      lfsr_q = 7'h00;
  logic            lfsr_en, lfsr_load, rnd_valid, period_done, busy;
  logic [6:0]      lfsr_seed, rnd_data;
  logic [NREQ-1:0] gnt;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  lfsr_req_sched #(.NREQ(NREQ), .STEPS(STEPS), .SEED(SEED)) dut (
    .clk(clk), .rst(rst), .seed_load(seed_load), .seed_in(seed_in), .req(req),
    .lfsr_q(lfsr_q), .lfsr_en(lfsr_en), .lfsr_load(lfsr_load), .lfsr_seed(lfsr_seed),
    .gnt(gnt), .rnd_valid(rnd_valid), .rnd_data(rnd_data),
    .period_done(period_done), .busy(busy)
  );

  // The shared LFSR instance the scheduler controls.
  always @(posedge clk) begin
    if (lfsr_en) lfsr_q <= lfsr_load ? lfsr_seed : {lfsr_q[5:0], lfsr_q[6] ^ lfsr_q[5]};
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef enum int {M_INIT, M_IDLE, M_XFER} mph_t;
  mph_t            m_ph;
  logic [6:0]      m_seed, m_lfsr;
  bit              m_pend;
  int              m_rr, m_idx, m_left, m_steps;
  logic [NREQ-1:0] e_gnt;
  logic            e_vld, e_pd;
  logic [6:0]      e_data;

  function automatic logic [6:0] lfsr_next(input logic [6:0] v);
    return {v[5:0], v[6] ^ v[5]};
  endfunction

  function automatic int pick(input logic [NREQ-1:0] r, input int ptr);
    logic [NREQ-1:0] sh;
    for (int k = 0; k < NREQ; k++) begin
      sh = r >> ((ptr + k) % NREQ);
      if (sh[0]) return (ptr + k) % NREQ;
    end
    return 0;
  endfunction

  task automatic model_reset();
    m_ph = M_INIT; m_seed = (SEED == 7'h00) ? 7'h01 : SEED; m_lfsr = '0;
    m_pend = 0; m_rr = 0; m_idx = 0; m_left = 0; m_steps = 0;
    e_gnt = '0; e_vld = 0; e_pd = 0; e_data = '0;
  endtask

  task automatic model_step();
    logic [6:0] nseed;
    nseed = seed_load ? ((seed_in == 7'h00) ? 7'h01 : seed_in) : m_seed;
    e_vld = 0;
    e_pd  = 0;
    case (m_ph)
      M_INIT: begin
        m_lfsr = m_seed; m_steps = 0; m_pend = 0; m_ph = M_IDLE;
      end
      M_IDLE: begin
        e_gnt = '0;
        if (m_pend) m_ph = M_INIT;
        else if (req != '0) begin
          m_idx = pick(req, m_rr);
          e_gnt = NREQ'(1) << m_idx;
          m_left = STEPS;
          m_ph = M_XFER;
        end
      end
      default: begin
        if (m_left > 0) begin
          m_lfsr = lfsr_next(m_lfsr);
          m_left--;
          m_steps++;
          if (m_steps == 127) begin e_pd = 1; m_steps = 0; end
        end else begin
          e_vld = 1; e_data = m_lfsr; m_rr = (m_idx + 1) % NREQ; m_ph = M_IDLE;
        end
      end
    endcase
    if (seed_load) m_pend = 1;
    m_seed = nseed;
  endtask

  task automatic compare();
    logic exp_en, exp_ld;
    exp_ld = !rst && (m_ph == M_INIT);
    exp_en = !rst && ((m_ph == M_INIT) || (m_ph == M_XFER && m_left > 0));
    chk("gnt",         32'(gnt),         32'(e_gnt));
    chk("rnd_valid",   32'(rnd_valid),   32'(e_vld));
    chk("rnd_data",    32'(rnd_data),    32'(e_data));
    chk("period_done", 32'(period_done), 32'(e_pd));
    chk("busy",        32'(busy),        32'(m_ph != M_IDLE));
    chk("lfsr_en",     32'(lfsr_en),     32'(exp_en));
    chk("lfsr_load",   32'(lfsr_load),   32'(exp_ld));
    chk("lfsr_seed",   32'(lfsr_seed),   32'(m_seed));
  endtask

  // ---------------- cycle driver / monitor ----------------
  logic [NREQ-1:0] dq_gnt[$];
  logic [6:0]      dq_data[$];
  int              dq_cyc[$];
  int              cyc = 0;
  int              pd_cnt = 0;

  task automatic tick();
    @(posedge clk);
    model_step();
    cyc++;
    @(negedge clk);
    compare();
    if (rnd_valid) begin
      dq_gnt.push_back(gnt); dq_data.push_back(rnd_data); dq_cyc.push_back(cyc);
    end
    if (period_done) pd_cnt++;
  endtask

  task automatic wait_deliv(input int n, input int budget);
    int target, k;
    target = dq_data.size() + n;
    k = 0;
    while (dq_data.size() < target && k < budget) begin tick(); k++; end
    if (dq_data.size() < target) chk("deliv_timeout", 32'(dq_data.size()), 32'(target));
  endtask

  // Called at a falling edge: reset lands mid-cycle, then releases two cycles later.
  task automatic do_reset();
    #2 rst = 1'b1;
    #1;
    model_reset();
    compare();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    cyc = 0;
  endtask

  logic [6:0]      exp_seq [7] = '{7'h02, 7'h04, 7'h08, 7'h10, 7'h20, 7'h41, 7'h03};
  logic [NREQ-1:0] exp_g   [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic [6:0]      exp_d   [5] = '{7'h02, 7'h04, 7'h08, 7'h10, 7'h20};

  initial begin
    int b, pd0, k;
    logic [NREQ-1:0] m;
    model_reset();
    @(negedge clk);
    do_reset();

    // Single requester from reset: known sequence and first-delivery latency.
    req = 4'b0001;
    b = dq_data.size();
    wait_deliv(7, 40);
    for (int i = 0; i < 7; i++) chk("seq_data", 32'(dq_data[b+i]), 32'(exp_seq[i]));
    chk("first_latency", 32'(dq_cyc[b]), 32'd4);

    // All requesting: round-robin order, values, spacing STEPS+2.
    do_reset();
    req = 4'b1111;
    b = dq_data.size();
    wait_deliv(5, 30);
    for (int i = 0; i < 5; i++) begin
      chk("rr_gnt", 32'(dq_gnt[b+i]), 32'(exp_g[i]));
      chk("rr_data", 32'(dq_data[b+i]), 32'(exp_d[i]));
    end
    for (int i = 0; i < 4; i++) chk("rr_spacing", 32'(dq_cyc[b+i+1] - dq_cyc[b+i]), 32'(STEPS + 2));

    // Wrap: index 2 alone twice (second time rr_ptr=3), then 3 before 0.
    req = 4'b0100;
    b = dq_data.size();
    wait_deliv(2, 20);
    req = 4'b1001;
    wait_deliv(2, 20);
    chk("wrap_g0", 32'(dq_gnt[b]),   32'(4'b0100));
    chk("wrap_g1", 32'(dq_gnt[b+1]), 32'(4'b0100));
    chk("wrap_g2", 32'(dq_gnt[b+2]), 32'(4'b1000));
    chk("wrap_g3", 32'(dq_gnt[b+3]), 32'(4'b0001));

    // Zero seed loaded mid-STEP, then a full 127-grant period.
    req = 4'b0001;
    k = 0;
    while (!(lfsr_en && !lfsr_load) && k < 20) begin tick(); k++; end
    if (!(lfsr_en && !lfsr_load)) chk("step_timeout", 32'(k), 32'd0);
    seed_load = 1'b1; seed_in = 7'h00;
    tick();
    seed_load = 1'b0;
    chk("seed_zero_map", 32'(lfsr_seed), 32'h01);
    wait_deliv(1, 10);
    pd0 = pd_cnt;
    b = dq_data.size();
    wait_deliv(127, 127 * (STEPS + 2) + 20);
    chk("period_first", 32'(dq_data[b]), 32'h02);
    chk("period_last", 32'(dq_data[b+126]), 32'h01);
    chk("period_pulses", 32'(pd_cnt - pd0), 32'd1);

    // Reset while a delivery is being presented.
    wait_deliv(1, 10);
    chk("pre_rst_vld", 32'(rnd_valid), 32'd1);
    do_reset();
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_vld", 32'(rnd_valid), 32'd0);
    b = dq_data.size();
    wait_deliv(1, 10);
    chk("post_rst_data", 32'(dq_data[b]), 32'h02);

    // Randomized traffic, seeds and occasional resets.
    for (int n = 0; n < 2500; n++) begin
      tick();
      for (int i = 0; i < NREQ; i++) begin
        m = NREQ'(1) << i;
        if (|(req & m)) begin
          if (|(gnt & m) && rnd_valid && $urandom_range(0, 3) != 0) req = req & ~m;
          else if ($urandom_range(0, 99) == 0) req = req & ~m;
        end else if ($urandom_range(0, 3) == 0) begin
          req = req | m;
        end
      end
      seed_load = ($urandom_range(0, 39) == 0);
      seed_in = ($urandom_range(0, 3) == 0) ? 7'h00 : 7'($urandom_range(0, 127));
      if ($urandom_range(0, 499) == 0) begin
        seed_load = 1'b0;
        do_reset();
      end
    end
    seed_load = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
